// File: rtl/conv_layer_sched.sv
// conv_layer_sched: loads P filters per group from weight RAM, starts the engines and
// serialises per-lane pixel results into one tagged ready/valid stream. Option: CONV_RELU_EN.
`timescale 1ns/1ps
`default_nettype none

module conv_layer_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int FW         = 64,
  parameter int K          = 64,
  parameter int P          = 2,
  parameter int NPIX       = 25600,
  localparam int AW        = (K*FW > 1) ? $clog2(K*FW) : 1,
  localparam int FIW       = (K > 1) ? $clog2(K) : 1,
  localparam int PXW       = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       w_rd_en,
  output logic [AW-1:0]              w_addr,
  input  logic [DATA_WIDTH-1:0]      w_rd_data,
  output logic [P*FW*DATA_WIDTH-1:0] lane_filters,
  output logic [P-1:0]               lane_mask,
  output logic                       eng_start,
  input  logic                       eng_valid,
  input  logic [P*DATA_WIDTH-1:0]    eng_data,
  output logic                       eng_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [FIW-1:0]             out_filt,
  output logic [PXW-1:0]             out_pix,
  output logic                       out_last
);

  localparam int NG  = (K + P - 1) / P;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int LW  = (P > 1) ? $clog2(P) : 1;
  localparam int WW  = (FW > 1) ? $clog2(FW) : 1;
  localparam int LFW = P * FW * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          g_q, g_d;
  logic [PXW-1:0]         pix_q, pix_d;
  logic [LW-1:0]          ld_lane_q, ld_lane_d;
  logic [WW-1:0]          ld_word_q, ld_word_d;
  logic                   ld_issued_q, ld_issued_d;
  logic                   pend_q, pend_d;
  logic [LW-1:0]          pend_lane_q, pend_lane_d;
  logic [WW-1:0]          pend_word_q, pend_word_d;
  logic                   pend_act_q, pend_act_d;
  logic [LFW-1:0]         lane_filters_q, lane_filters_d;
  logic [P-1:0]           lane_mask_q, lane_mask_d;
  logic [P*DATA_WIDTH-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [LW-1:0]          lane_q, lane_d;

  logic [31:0]            base_k;
  logic [31:0]            n_act;
  logic [LW-1:0]          last_lane;
  logic                   last_group;
  logic                   last_pix;
  logic                   out_fire;
  logic                   last_fire;
  logic [31:0]            rd_k;
  logic                   rd_act;
  logic [DATA_WIDTH-1:0]  sel_word;

  // Lanes 0..n_act-1 of the current group carry real filters.
  assign base_k     = 32'(g_q) * 32'(P);
  assign n_act      = ((32'(K) - base_k) > 32'(P)) ? 32'(P) : (32'(K) - base_k);
  assign last_lane  = LW'(n_act - 32'd1);
  assign last_group = (32'(g_q) == 32'(NG - 1));
  assign last_pix   = (32'(pix_q) == 32'(NPIX - 1));
  assign out_fire   = (state_q == S_RUN) && hold_full_q && out_ready;
  assign last_fire  = out_fire && (lane_q == last_lane);
  assign sel_word   = hold_q[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_d        = state_q;
    g_d            = g_q;
    pix_d          = pix_q;
    ld_lane_d      = ld_lane_q;
    ld_word_d      = ld_word_q;
    ld_issued_d    = ld_issued_q;
    pend_d         = 1'b0;
    pend_lane_d    = pend_lane_q;
    pend_word_d    = pend_word_q;
    pend_act_d     = pend_act_q;
    lane_filters_d = lane_filters_q;
    lane_mask_d    = lane_mask_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    lane_d         = lane_q;
    rd_k           = base_k + 32'(ld_lane_q);
    rd_act         = 1'b0;
    w_rd_en        = 1'b0;
    w_addr         = '0;
    eng_start      = 1'b0;
    eng_ready      = 1'b0;
    done           = 1'b0;

    if (state_q != S_LOAD) begin
      ld_lane_d   = '0;
      ld_word_d   = '0;
      ld_issued_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        g_d         = '0;
        pix_d       = '0;
        hold_full_d = 1'b0;
        lane_d      = '0;
        if (start) state_d = S_LOAD;
      end

      S_LOAD: begin
        if (!ld_issued_q) begin
          rd_act      = (rd_k < 32'(K));
          w_rd_en     = rd_act;
          if (rd_act) w_addr = AW'(rd_k * 32'(FW) + 32'(ld_word_q));
          pend_d      = 1'b1;
          pend_lane_d = ld_lane_q;
          pend_word_d = ld_word_q;
          pend_act_d  = rd_act;
          if (32'(ld_word_q) == 32'(FW - 1)) begin
            ld_word_d = '0;
            if (32'(ld_lane_q) == 32'(P - 1)) ld_issued_d = 1'b1;
            else                              ld_lane_d   = ld_lane_q + LW'(1);
          end else begin
            ld_word_d = ld_word_q + WW'(1);
          end
        end
        // RAM data lands one cycle after its strobe; masked lanes are zero-filled.
        if (pend_q) begin
          lane_filters_d[(int'(pend_lane_q)*FW + int'(pend_word_q))*DATA_WIDTH +: DATA_WIDTH] =
            pend_act_q ? w_rd_data : '0;
        end
        if (ld_issued_q) begin
          state_d = S_START;
          for (int l = 0; l < P; l++) lane_mask_d[l] = ((base_k + 32'(l)) < 32'(K));
        end
      end

      S_START: begin
        eng_start   = 1'b1;
        pix_d       = '0;
        hold_full_d = 1'b0;
        lane_d      = '0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        // Refill in the same cycle the last lane drains, unless that beat is the group's final pixel.
        eng_ready = !hold_full_q || (last_fire && !last_pix);
        if (out_fire && !last_fire) lane_d = lane_q + LW'(1);
        if (last_fire) begin
          hold_full_d = 1'b0;
          lane_d      = '0;
          if (last_pix) begin
            pix_d = '0;
            if (last_group) begin
              state_d = S_DONE;
            end else begin
              g_d     = g_q + GW'(1);
              state_d = S_LOAD;
            end
          end else begin
            pix_d = pix_q + PXW'(1);
          end
        end
        if (eng_valid && eng_ready) begin
          hold_d      = eng_data;
          hold_full_d = 1'b1;
          lane_d      = '0;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      g_q            <= '0;
      pix_q          <= '0;
      ld_lane_q      <= '0;
      ld_word_q      <= '0;
      ld_issued_q    <= 1'b0;
      pend_q         <= 1'b0;
      pend_lane_q    <= '0;
      pend_word_q    <= '0;
      pend_act_q     <= 1'b0;
      lane_filters_q <= '0;
      lane_mask_q    <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      lane_q         <= '0;
    end else begin
      state_q        <= state_d;
      g_q            <= g_d;
      pix_q          <= pix_d;
      ld_lane_q      <= ld_lane_d;
      ld_word_q      <= ld_word_d;
      ld_issued_q    <= ld_issued_d;
      pend_q         <= pend_d;
      pend_lane_q    <= pend_lane_d;
      pend_word_q    <= pend_word_d;
      pend_act_q     <= pend_act_d;
      lane_filters_q <= lane_filters_d;
      lane_mask_q    <= lane_mask_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      lane_q         <= lane_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign lane_filters = lane_filters_q;
  assign lane_mask    = lane_mask_q;
  assign out_valid    = (state_q == S_RUN) && hold_full_q;
  assign out_filt     = FIW'(base_k + 32'(lane_q));
  assign out_pix      = pix_q;
  assign out_last     = hold_full_q && last_group && last_pix && (lane_q == last_lane);

`ifdef CONV_RELU_EN
  assign out_data = sel_word[DATA_WIDTH-1] ? '0 : sel_word;
`else
  assign out_data = sel_word;
`endif

endmodule

`default_nettype wire

// File: doc/conv_layer_sched.md
# conv_layer_sched

Parametrised filter-group sequencer for float16 convolution layers: it runs K filters through P parallel single-filter convolution engines, P filters per pass. For each group it loads filter weights from a weight RAM into per-lane registers, starts the engines, and serialises their per-pixel outputs into one ready/valid stream tagged with filter and pixel index. It handles K not divisible by P by masking lanes, and supports backpressure. It sits between the weight RAM, the engine array and the layer output buffer.

## Interface
- DATA_WIDTH, 16: float16 word width.
- FW, 64: words per filter (D*F*F).
- K, 64: number of filters.
- P, 2: parallel engine lanes, 1..K.
- NPIX, 25600: output pixels per filter ((H-F+1)*(W-F+1)).
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin layer; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last output word is accepted.
- w_rd_en  out  1  weight RAM read strobe.
- w_addr  out  $clog2(K*FW)  word address: filter k, word j at k*FW+j.
- w_rd_data  in  DATA_WIDTH  valid exactly one cycle after w_rd_en.
- lane_filters  out  P*FW*DATA_WIDTH  lane l holds slice [l*FW*DATA_WIDTH +: FW*DATA_WIDTH].
- lane_mask  out  P  bit l set when lane l holds a real filter this group.
- eng_start  out  1  one-cycle pulse that starts the engines.
- eng_valid  in  1  engines present one pixel per lane.
- eng_data  in  P*DATA_WIDTH  lane l at [l*DATA_WIDTH +: DATA_WIDTH].
- eng_ready  out  1  beat accepted when eng_valid && eng_ready.
- out_valid, out_ready  out/in  1  output handshake.
- out_data  out  DATA_WIDTH  result word.
- out_filt  out  $clog2(K)  filter index of out_data.
- out_pix  out  $clog2(NPIX)  pixel index of out_data.
- out_last  out  1  set on the final word of the layer.

## Operation
- States: IDLE, LOAD, START, RUN, DONE.
- NG = ceil(K/P) groups. Group g, lane l maps to filter k = g*P+l. The lane is active when k < K.
- IDLE: all counters cleared. start=1 moves to LOAD with g=0.
- LOAD: issues P*FW reads, lane-major then word-order, one per cycle, only for active lanes. Inactive lanes are written with zero and no read is issued. Returned data is written to the lane/word that was addressed one cycle earlier. When the last write lands, move to START.
- START: lane_mask is updated and eng_start pulses for one cycle. Move to RUN.
- RUN: a one-beat holding register stores eng_data.
  - eng_ready = register empty, or the register is emitting its last active lane and out_ready=1 in that cycle (zero-bubble refill).
  - Active lanes are emitted in ascending l. out_filt=g*P+l, out_pix is the current pixel counter.
  - The pixel counter increments when the last active lane of a beat is accepted.
  - After pixel NPIX-1 is fully accepted: if g<NG-1, increment g and go to LOAD; otherwise go to DONE.
  - eng_valid outside RUN is ignored; eng_ready=0 outside RUN.
- DONE: done=1 for one cycle, then IDLE.
- out_last = (g==NG-1) && (pix==NPIX-1) && (lane is the last active lane).
- start while busy is ignored.
- lane_filters and lane_mask hold their values from the last load until the next LOAD overwrites them.

## Timing
- Reset values: busy=0, done=0, w_rd_en=0, w_addr=0, lane_filters=0, lane_mask=0, eng_start=0, eng_ready=0, out_valid=0, out_data=0, out_filt=0, out_pix=0, out_last=0. State = IDLE.
- An active reset mid-layer aborts immediately. Nothing resumes; a new start is required.
- start at cycle t: first w_rd_en at t+1.
- LOAD of a full group takes P*FW+1 cycles. eng_start follows 2 cycles after the last read strobe.
- eng beat accepted at cycle t: first out_valid at t+1.
- Stalled output (out_valid=1, out_ready=0): out_data, out_filt, out_pix and out_last are held stable.
- Full throughput is P output words per P cycles.

## Configuration
- CONV_RELU_EN defined: any output word with MSB=1 (negative, including -0) is emitted as 16'h0000. There is no extra latency.
- CONV_RELU_EN undefined: words pass unchanged.

## Test plan
- K=4, P=2, FW=2, NPIX=3, weights = address: lanes get {0,1},{2,3}, then {4,5},{6,7}. Expect 2 eng_start pulses, 12 outputs with out_filt order 0,1,0,1,0,1,2,3,... and out_last only on the 12th word.
- K=3, P=2: group 1 lane_mask=2'b01, lane 1 filters zero and no read for filter 3. Expect 9 outputs total, last one with out_filt=2, out_pix=2.
- Random out_ready (50%) and random eng_valid: no word lost or duplicated, and outputs are stable while stalled.
- Assert reset low mid-RUN, then release and start again: all outputs return to reset values and the layer runs completely from g=0.
- With CONV_RELU_EN: eng_data lane words 16'hBC00 and 16'h3C00 are emitted as 16'h0000 and 16'h3C00. Without it, 16'hBC00 is emitted unchanged.
- start pulsed during RUN: no effect. done pulses exactly once, one cycle after the last accepted word.
